// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO in front of a UART transmitter. The host pushes bytes;
//            a small drain FSM pops one byte at a time into a held tx_data
//            register and pulses tx_start, then waits for the transmitter's
//            busy handshake, or for a short timeout, before sending the next.
// Ports    : ipclk            - sole clock, rising edge
//            rstn             - asynchronous active-low reset
//            wr_en / wr_data  - host write strobe and byte
//            full / empty     - occupancy flags derived from count
//            overflow/clr_ovf - sticky dropped-write flag and its clear
//            tx_data/tx_start - byte and one-cycle start pulse to transmitter
//            tx_busy          - transmitter is shifting a frame
//            level            - occupancy 0..DEPTH (UART_TX_FIFO_LEVEL_EN only)
// Config   : define UART_TX_FIFO_LEVEL_EN to add the level output port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          ipclk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [7:0]    tx_data,
  output logic          tx_start,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [AW:0]   level,
`endif
  input  logic          tx_busy
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;
  logic [7:0]    tx_data_q;
  logic          tx_start_q, tx_start_d;
  state_t        state_q, state_d;
  logic [1:0]    tmo_q, tmo_d;
  logic          w_push, w_pop, w_empty, w_full;

  assign w_full  = (count_q == C_DEPTH);
  assign w_empty = (count_q == '0);
  // Writes are gated by the full flag at the start of the cycle, so a pop in
  // the same cycle never rescues a write into a full FIFO.
  assign w_push  = wr_en & ~w_full;

  // Drain FSM: next state, pop request and start pulse.
  always_comb begin
    state_d    = state_q;
    tmo_d      = 2'd0;
    tx_start_d = 1'b0;
    w_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_pop      = 1'b1;
          tx_start_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        // Transmitter never acknowledged: after 4 idle cycles assume sent.
        if (tx_busy) state_d = WAIT_DONE;
        else if (tmo_q == 2'd3) state_d = IDLE;
        else tmo_d = tmo_q + 2'd1;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array is not reset; occupancy is tracked entirely by count.
  always_ff @(posedge ipclk) begin
    if (w_push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge ipclk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      state_q    <= IDLE;
      tmo_q      <= 2'd0;
    end else begin
      count_q    <= count_d;
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      tx_start_q <= tx_start_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        tx_data_q <= mem[rd_ptr_q];
      end
      // A dropped write in the same cycle as a clear keeps the flag set.
      if (wr_en && w_full) overflow_q <= 1'b1;
      else if (clr_ovf)    overflow_q <= 1'b0;
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo (DEPTH=8). Covers
//            reset values, single byte, fill/overflow, ordered drain, write+pop
//            at count 3 with pointer wrap, busy timeout and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic       ipclk = 1'b0;
  logic       rstn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, clr_ovf;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [3:0] level;
`endif

  // 0: busy tied low, 1: busy tied high, 2: reactive transmitter model
  int         busy_mode = 0;
  logic       busy_model = 1'b0;
  logic [7:0] cap[$];
  int         n_checks = 0;
  int         n_fail = 0;

  assign tx_busy = (busy_mode == 2) ? busy_model : (busy_mode == 1);

  uart_tx_fifo #(.DEPTH(8), .AW(3)) dut (
    .ipclk    (ipclk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .tx_data  (tx_data),
    .tx_start (tx_start),
`ifdef UART_TX_FIFO_LEVEL_EN
    .level    (level),
`endif
    .tx_busy  (tx_busy)
  );

  always #5 ipclk = ~ipclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Capture every byte presented with a start pulse.
  initial begin
    forever begin
      @(negedge ipclk);
      if (tx_start === 1'b1) cap.push_back(tx_data);
    end
  end

  // Transmitter model: busy rises one cycle after tx_start, lasts 10 cycles.
  initial begin
    forever begin
      @(negedge ipclk);
      if (busy_mode == 2 && tx_start === 1'b1) begin
        @(negedge ipclk);
        busy_model = 1'b1;
        repeat (10) @(negedge ipclk);
        busy_model = 1'b0;
      end
    end
  end

  initial begin
    int sent;
    rstn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
    repeat (3) @(negedge ipclk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'h00);
    check("rst_txstart", 32'(tx_start), 32'd0);
    rstn = 1'b1;

    // ---- Single byte with transmitter model ----
    busy_mode = 2;
    @(negedge ipclk); wr_en = 1'b1; wr_data = 8'hAA;
    @(negedge ipclk); wr_en = 1'b0;
    check("t1_empty_after_wr", 32'(empty), 32'd0);
    check("t1_start_early", 32'(tx_start), 32'd0);
    @(negedge ipclk);
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_data", 32'(tx_data), 32'hAA);
    check("t1_empty_after_pop", 32'(empty), 32'd1);
    @(negedge ipclk);
    check("t1_start_one_cycle", 32'(tx_start), 32'd0);
    repeat (20) @(negedge ipclk);
    check("t1_pulses", 32'(cap.size()), 32'd1);
    check("t1_idle", 32'(dut.state_q), 32'd0);
    check("t1_data_held", 32'(tx_data), 32'hAA);

    // ---- Fill and overflow with busy held high ----
    busy_mode = 1;
    cap.delete();
    for (int i = 1; i <= 9; i++) begin
      @(negedge ipclk);
      if (i == 9) begin
        check("t2_full_after8", 32'(full), 32'd1);
        check("t2_ovf_before9", 32'(overflow), 32'd0);
      end
      wr_en = 1'b1; wr_data = 8'(i);
    end
    @(negedge ipclk); wr_en = 1'b0;
    check("t2_full", 32'(full), 32'd1);
    check("t2_empty", 32'(empty), 32'd0);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_count", 32'(dut.count_q), 32'd8);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("t2_level", 32'(level), 32'd8);
`endif
    check("t2_no_start", 32'(cap.size()), 32'd0);

    // ---- Ordered drain ----
    busy_mode = 2;
    repeat (160) @(negedge ipclk);
    check("t3_pulses", 32'(cap.size()), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t3_order%0d", i), 32'(cap[i]), 32'(i + 1));
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(negedge ipclk); clr_ovf = 1'b0;
    check("t3_ovf_cleared", 32'(overflow), 32'd0);

    // ---- Write+pop at count 3, then wrap 20 more bytes ----
    busy_mode = 1;
    cap.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge ipclk); wr_en = 1'b1; wr_data = 8'(8'h10 + i);
    end
    @(negedge ipclk);
    check("t4_count3", 32'(dut.count_q), 32'd3);
    busy_mode = 0; wr_data = 8'h13;
    @(negedge ipclk); wr_en = 1'b0;
    check("t4_count_same", 32'(dut.count_q), 32'd3);
    check("t4_start", 32'(tx_start), 32'd1);
    sent = 0;
    for (int k = 0; k < 300 && sent < 20; k++) begin
      @(negedge ipclk);
      if (!full) begin
        wr_en = 1'b1; wr_data = 8'(8'h14 + sent); sent++;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge ipclk); wr_en = 1'b0;
    check("t4_all_written", 32'(sent), 32'd20);
    repeat (200) @(negedge ipclk);
    check("t4_pulses", 32'(cap.size()), 32'd24);
    for (int i = 0; i < 24; i++) check($sformatf("t4_order%0d", i), 32'(cap[i]), 32'(8'h10 + i));
    check("t4_ovf", 32'(overflow), 32'd0);

    // ---- Timeout with busy tied low ----
    cap.delete();
    @(negedge ipclk); wr_en = 1'b1; wr_data = 8'h55;
    @(negedge ipclk); wr_data = 8'h66;
    @(negedge ipclk); wr_en = 1'b0;
    check("t5_start55", 32'(tx_start), 32'd1);
    check("t5_data55", 32'(tx_data), 32'h55);
    for (int i = 0; i < 4; i++) begin
      @(negedge ipclk);
      check($sformatf("t5_wait_busy%0d", i), 32'(dut.state_q), 32'd2);
    end
    @(negedge ipclk);
    check("t5_idle", 32'(dut.state_q), 32'd0);
    @(negedge ipclk);
    check("t5_start66", 32'(tx_start), 32'd1);
    check("t5_data66", 32'(tx_data), 32'h66);
    repeat (10) @(negedge ipclk);

    // ---- Reset during WAIT_DONE ----
    busy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ipclk); wr_en = 1'b1; wr_data = 8'(8'h31 + i);
    end
    @(negedge ipclk); wr_en = 1'b0;
    busy_mode = 2;
    repeat (5) @(negedge ipclk);
    check("t6_wait_done", 32'(dut.state_q), 32'd3);
    rstn = 1'b0;
    #1;
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_full", 32'(full), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    check("t6_rst_txdata", 32'(tx_data), 32'h00);
    check("t6_rst_txstart", 32'(tx_start), 32'd0);
    check("t6_rst_state", 32'(dut.state_q), 32'd0);
    check("t6_rst_count", 32'(dut.count_q), 32'd0);
    repeat (2) @(negedge ipclk);
    rstn = 1'b1; busy_mode = 0;
    cap.delete();
    repeat (12) @(negedge ipclk);
    check("t6_no_start", 32'(cap.size()), 32'd0);
    check("t6_empty_post", 32'(empty), 32'd1);
    @(negedge ipclk); wr_en = 1'b1; wr_data = 8'h77;
    @(negedge ipclk); wr_en = 1'b0;
    repeat (3) @(negedge ipclk);
    check("t6_new_pulses", 32'(cap.size()), 32'd1);
    check("t6_new_data", 32'(cap[0]), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
